decode_queue: RTL
=================

# decode_queue

Parametrised instruction decode queue between instruction fetch and issue. Each fetched word is decoded when it is accepted, and the decoded fields are stored in a DEPTH-entry circular buffer. The head entry is presented to issue under a valid/ready handshake. Compared with a purely combinational decoder, it adds buffering, flush on redirect, a global pause, illegal-instruction detection, and zeroing of `rd` for stores and branches.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, 2 or more.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk_in  in  1  single clock; all state updates on the rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; while low, all state holds.
- flush  in  1  redirect; empties the queue.
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  queue can accept a word.
- in_inst  in  32  instruction word.
- in_pc  in  32  PC of the instruction word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  issue consumes the head entry.
- out_op  out  5  internal op code from the shared op definitions.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  32  decoded immediate.
- out_use_imm, out_branch, out_ls, out_jalr, out_illegal  out  1 each  decode flags.
- out_pc  out  32  PC of the head entry.
- count  out  CNT_W  number of occupied entries.

## Operation
- Decode is combinational on in_inst and is written into the entry at the write pointer on enqueue. All out_* fields come straight from the entry at the read pointer; there is no combinational path from in_* to out_*.
- Supported instructions are RV32I BIN, IMM, LD, ST, BR, JAL, JALR, AUIPC and LUI.
- Immediate formats:
  - I-type: sign-extended inst[31:20].
  - Shift-immediates: zero-extended inst[24:20].
  - S-type: sign-extended {inst[31:25], inst[11:7]}.
  - B-type: sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J-type: sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - U-type: {inst[31:12], 12'b0}.
- Flag definitions:
  - use_imm is 0 only for BIN; 1 for every other op.
  - ls is 1 for LD and ST.
  - branch is 1 for BR, JAL and JALR.
  - jalr is 1 for JALR only.
- rd is forced to 0 for ST and BR. rs1 and rs2 are always the raw fields.
- out_illegal = 1 when any of the following holds:
  - opcode is outside the supported set;
  - LD funct3 is 011, 110 or 111;
  - ST funct3 is greater than 010;
  - BR funct3 is 010 or 011;
  - JALR funct3 is not 000;
  - BIN funct7 is neither 0000000 nor 0100000;
  - BIN funct7 is 0100000 with funct3 other than 000 or 101;
  - IMM shift with inst[31:25] not 0000000, or not 0100000 for SRAI.
- An illegal entry is still queued, with op=0, rd=0, use_imm=0, branch=0, ls=0, jalr=0, imm=0, and the PC preserved.
- Enqueue occurs when in_valid && in_ready && rdy_in && !flush.
- Dequeue occurs when out_valid && out_ready && rdy_in && !flush.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count rules: +1 on enqueue only, −1 on dequeue only, unchanged when both occur in the same cycle.

## Timing
- Reset (rst_in=1 at an edge):
  - pointers = 0, count = 0;
  - every entry's fields = 0, so out_* = 0 and out_valid = 0;
  - reset overrides flush and rdy_in.
- in_ready = rdy_in && (count < DEPTH). A full queue refuses input even if a dequeue happens in the same cycle.
- out_valid = rdy_in && (count != 0).
- Latency: a word enqueued at edge N is visible on out_* after edge N, i.e. out_valid is high in cycle N+1 if the queue was empty.
- Flush:
  - it has priority over enqueue and dequeue in the same cycle;
  - after the edge, count = 0 and pointers = 0;
  - in_ready may be high during the flush cycle, but the word is dropped.
- rdy_in=0: no pointer, count or entry updates; in_ready=0 and out_valid=0; out_* data holds its value.
- Reset or flush mid-stream discards all entries. The first word accepted afterwards is at entry 0.

## Test plan
- Reset, then enqueue 0x00500093 (addi x1,x0,5) at PC 0x0 -> next cycle out_valid=1, op=ADD, rd=1, rs1=0, imm=5, use_imm=1, illegal=0, count=1.
- Enqueue 0x402081B3 (sub), then 0xFE000CE3 (beq x0,x0,-8), with out_ready=1 -> in order: op SUB, use_imm=0; then op BEQ, imm=0xFFFFFFF8, rd=0, branch=1.
- Hold out_ready=0 and offer DEPTH+1 words -> in_ready drops after DEPTH enqueues and count=DEPTH. Then assert out_ready for one cycle with in_valid high -> count stays DEPTH−1 after that cycle; in_ready returns the cycle after. Drain order matches fetch order across pointer wrap.
- Enqueue 0x00003003 (LD funct3=011) and 0x0000707F -> both dequeue with illegal=1, op=0, imm=0; PCs intact.
- With 3 entries queued, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0; the flushed-cycle word never appears.
- Drop rdy_in for 3 cycles while 0x123452B7 (lui x5) is queued -> in_ready=0, out_valid=0, count frozen. When rdy_in returns -> op LUI, rd=5, imm=0x12345000.

Source files
------------

// File: rtl/decode_queue.sv
// RV32I decode queue: words are decoded on acceptance and held in a DEPTH-entry
// circular buffer whose head entry is offered to issue under valid/ready.
package decode_queue_pkg;

  typedef enum logic [4:0] {
    OP_NONE  = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_SLL   = 5'd3,
    OP_SLT   = 5'd4,
    OP_SLTU  = 5'd5,
    OP_XOR   = 5'd6,
    OP_SRL   = 5'd7,
    OP_SRA   = 5'd8,
    OP_OR    = 5'd9,
    OP_AND   = 5'd10,
    OP_LB    = 5'd11,
    OP_LH    = 5'd12,
    OP_LW    = 5'd13,
    OP_LBU   = 5'd14,
    OP_LHU   = 5'd15,
    OP_SB    = 5'd16,
    OP_SH    = 5'd17,
    OP_SW    = 5'd18,
    OP_BEQ   = 5'd19,
    OP_BNE   = 5'd20,
    OP_BLT   = 5'd21,
    OP_BGE   = 5'd22,
    OP_BLTU  = 5'd23,
    OP_BGEU  = 5'd24,
    OP_JAL   = 5'd25,
    OP_JALR  = 5'd26,
    OP_AUIPC = 5'd27,
    OP_LUI   = 5'd28
  } op_e;

  localparam logic [6:0] OPC_BIN   = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic        branch;
    logic        ls;
    logic        jalr;
    logic        illegal;
    logic [31:0] pc;
  } entry_t;

endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_op,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [31:0]       out_imm,
  output logic              out_use_imm,
  output logic              out_branch,
  output logic              out_ls,
  output logic              out_jalr,
  output logic              out_illegal,
  output logic [31:0]       out_pc,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [6:0]  opc_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [31:0] imm_i_s, imm_sh_s, imm_st_s, imm_b_s, imm_j_s, imm_u_s;
  entry_t      raw_s;
  entry_t      dec_s;
  entry_t      head_s;
  logic        bad_s;
  logic        rd_zero_s;
  logic        enq_s;
  logic        deq_s;

  assign opc_s = in_inst[6:0];
  assign f3_s  = in_inst[14:12];
  assign f7_s  = in_inst[31:25];

  assign imm_i_s  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_sh_s = {27'd0, in_inst[24:20]};
  assign imm_st_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b_s  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
  assign imm_j_s  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
  assign imm_u_s  = {in_inst[31:12], 12'd0};

  // Field decode of the incoming word; bad_s flags anything outside RV32I base.
  always_comb begin
    raw_s         = '0;
    raw_s.rs1     = in_inst[19:15];
    raw_s.rs2     = in_inst[24:20];
    raw_s.pc      = in_pc;
    raw_s.use_imm = 1'b1;
    bad_s         = 1'b0;
    rd_zero_s     = 1'b0;
    case (opc_s)
      OPC_BIN: begin
        raw_s.use_imm = 1'b0;
        if (f7_s == F7_BASE) begin
          case (f3_s)
            3'b000:  raw_s.op = OP_ADD;
            3'b001:  raw_s.op = OP_SLL;
            3'b010:  raw_s.op = OP_SLT;
            3'b011:  raw_s.op = OP_SLTU;
            3'b100:  raw_s.op = OP_XOR;
            3'b101:  raw_s.op = OP_SRL;
            3'b110:  raw_s.op = OP_OR;
            3'b111:  raw_s.op = OP_AND;
            default: bad_s    = 1'b1;
          endcase
        end else if (f7_s == F7_ALT) begin
          case (f3_s)
            3'b000:  raw_s.op = OP_SUB;
            3'b101:  raw_s.op = OP_SRA;
            default: bad_s    = 1'b1;
          endcase
        end else begin
          bad_s = 1'b1;
        end
      end
      OPC_IMM: begin
        raw_s.imm = imm_i_s;
        case (f3_s)
          3'b000: raw_s.op = OP_ADD;
          3'b010: raw_s.op = OP_SLT;
          3'b011: raw_s.op = OP_SLTU;
          3'b100: raw_s.op = OP_XOR;
          3'b110: raw_s.op = OP_OR;
          3'b111: raw_s.op = OP_AND;
          3'b001: begin
            raw_s.op  = OP_SLL;
            raw_s.imm = imm_sh_s;
            bad_s     = (f7_s != F7_BASE);
          end
          3'b101: begin
            raw_s.imm = imm_sh_s;
            if (f7_s == F7_BASE) begin
              raw_s.op = OP_SRL;
            end else if (f7_s == F7_ALT) begin
              raw_s.op = OP_SRA;
            end else begin
              bad_s = 1'b1;
            end
          end
          default: bad_s = 1'b1;
        endcase
      end
      OPC_LD: begin
        raw_s.imm = imm_i_s;
        raw_s.ls  = 1'b1;
        case (f3_s)
          3'b000:  raw_s.op = OP_LB;
          3'b001:  raw_s.op = OP_LH;
          3'b010:  raw_s.op = OP_LW;
          3'b100:  raw_s.op = OP_LBU;
          3'b101:  raw_s.op = OP_LHU;
          default: bad_s    = 1'b1;
        endcase
      end
      OPC_ST: begin
        raw_s.imm = imm_st_s;
        raw_s.ls  = 1'b1;
        rd_zero_s = 1'b1;
        case (f3_s)
          3'b000:  raw_s.op = OP_SB;
          3'b001:  raw_s.op = OP_SH;
          3'b010:  raw_s.op = OP_SW;
          default: bad_s    = 1'b1;
        endcase
      end
      OPC_BR: begin
        raw_s.imm    = imm_b_s;
        raw_s.branch = 1'b1;
        rd_zero_s    = 1'b1;
        case (f3_s)
          3'b000:  raw_s.op = OP_BEQ;
          3'b001:  raw_s.op = OP_BNE;
          3'b100:  raw_s.op = OP_BLT;
          3'b101:  raw_s.op = OP_BGE;
          3'b110:  raw_s.op = OP_BLTU;
          3'b111:  raw_s.op = OP_BGEU;
          default: bad_s    = 1'b1;
        endcase
      end
      OPC_JAL: begin
        raw_s.op     = OP_JAL;
        raw_s.imm    = imm_j_s;
        raw_s.branch = 1'b1;
      end
      OPC_JALR: begin
        raw_s.op     = OP_JALR;
        raw_s.imm    = imm_i_s;
        raw_s.branch = 1'b1;
        raw_s.jalr   = 1'b1;
        bad_s        = (f3_s != 3'b000);
      end
      OPC_AUIPC: begin
        raw_s.op  = OP_AUIPC;
        raw_s.imm = imm_u_s;
      end
      OPC_LUI: begin
        raw_s.op  = OP_LUI;
        raw_s.imm = imm_u_s;
      end
      default: bad_s = 1'b1;
    endcase
  end

  // Illegal words keep only register fields and PC so issue can trap precisely.
  always_comb begin
    dec_s = raw_s;
    if (bad_s) begin
      dec_s         = '0;
      dec_s.rs1     = raw_s.rs1;
      dec_s.rs2     = raw_s.rs2;
      dec_s.pc      = raw_s.pc;
      dec_s.illegal = 1'b1;
    end else if (rd_zero_s) begin
      dec_s.rd = 5'd0;
    end else begin
      dec_s.rd = in_inst[11:7];
    end
  end

  assign in_ready  = rdy_in && (count_q < CNT_W'(DEPTH));
  assign out_valid = rdy_in && (count_q != {CNT_W{1'b0}});
  assign enq_s     = in_valid && in_ready && rdy_in && !flush;
  assign deq_s     = out_valid && out_ready && rdy_in && !flush;

  // Pointer and occupancy next state; a paused queue ignores flush as well.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rdy_in && flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state and entry storage.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (enq_s) begin
        mem_q[wr_ptr_q] <= dec_s;
      end
    end
  end

  assign head_s      = mem_q[rd_ptr_q];
  assign out_op      = head_s.op;
  assign out_rd      = head_s.rd;
  assign out_rs1     = head_s.rs1;
  assign out_rs2     = head_s.rs2;
  assign out_imm     = head_s.imm;
  assign out_use_imm = head_s.use_imm;
  assign out_branch  = head_s.branch;
  assign out_ls      = head_s.ls;
  assign out_jalr    = head_s.jalr;
  assign out_illegal = head_s.illegal;
  assign out_pc      = head_s.pc;
  assign count       = count_q;

endmodule
